// File: rtl/r88_memctl.sv
// rtl/r88_memctl.sv - Rocket88 external memory bus controller
//
// Holds the external memory address register and runs one read or write bus
// cycle at a time: IDLE -> SETUP -> ACCESS -> DONE -> IDLE. ACCESS asserts the
// strobe for WAIT_STATES+1 cycles. In the default build memReady has no
// effect. Defining R88_MEMCTL_READY_EN lets memReady=0 stretch ACCESS after
// the wait count has expired.
//
// Ports:
//   sysClock       system clock, rising edge
//   resetReq       asynchronous active-low reset
//   extA           external address bus, always the address register
//   extD           external data bus, driven only in SETUP/ACCESS of a write
//   readMem        read strobe (ACCESS of a read)
//   writeMem       write strobe (ACCESS of a write)
//   memReady       external ready, honoured only with R88_MEMCTL_READY_EN
//   regAddr        full address source for addrLoadFull
//   addrLoadFull   load whole address register from regAddr (IDLE only)
//   addrLoadByte   load byte lane addrByteSel from intDIn (IDLE only)
//   addrByteSel    byte lane, 0 = bits [7:0]; lanes past the top are ignored
//   intDIn         write data / address byte
//   rdReq, wrReq   start a read / write (read wins when both are high)
//   incAfter       increment the address in DONE of this access
//   rdData         last byte read, held until the next read completes
//   busy           state is not IDLE
//   done           one-cycle pulse in DONE
module r88_memctl #(
  parameter int ADDR_W      = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic                        sysClock,
  input  logic                        resetReq,
  output logic [ADDR_W-1:0]           extA,
  inout  wire  [7:0]                  extD,
  output logic                        readMem,
  output logic                        writeMem,
  input  logic                        memReady,
  input  logic [ADDR_W-1:0]           regAddr,
  input  logic                        addrLoadFull,
  input  logic                        addrLoadByte,
  input  logic [$clog2(ADDR_W/8)-1:0] addrByteSel,
  input  logic [7:0]                  intDIn,
  input  logic                        rdReq,
  input  logic                        wrReq,
  input  logic                        incAfter,
  output logic [7:0]                  rdData,
  output logic                        busy,
  output logic                        done
);

  localparam int NBYTES = ADDR_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } stateT;

  stateT             stateQ;
  stateT             stateD;

  logic [ADDR_W-1:0] addrQ;
  logic [ADDR_W-1:0] addrD;
  logic [7:0]        rdDataQ;
  logic [7:0]        wrDataQ;
  logic              isWriteQ;
  logic              incQ;
  logic [3:0]        waitCnt;
  logic              readyOk;
  logic              accessExit;
  logic              driveD;

`ifdef R88_MEMCTL_READY_EN
  assign readyOk = memReady;
`else
  // Fixed-length access: memReady is folded away and may float.
  assign readyOk = memReady | 1'b1;
`endif

  assign accessExit = (waitCnt == 4'd0) && readyOk;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge sysClock or negedge resetReq) begin
    if (!resetReq) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE:    if (rdReq || wrReq) stateD = SETUP;
      SETUP:   stateD = ACCESS;
      ACCESS:  if (accessExit) stateD = DONE;
      DONE:    stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    readMem  = 1'b0;
    writeMem = 1'b0;
    driveD   = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (stateQ)
      IDLE:    busy = 1'b0;
      SETUP:   driveD = isWriteQ;
      ACCESS: begin
        readMem  = ~isWriteQ;
        writeMem = isWriteQ;
        driveD   = isWriteQ;
      end
      DONE:    done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Write data is on the bus one cycle before writeMem rises and is released
  // as soon as the controller leaves ACCESS (or reset forces IDLE).
  assign extD   = driveD ? wrDataQ : 8'bz;
  assign extA   = addrQ;
  assign rdData = rdDataQ;

  // ---------------------------------------------------------------------------
  // Address register next value
  // ---------------------------------------------------------------------------
  always_comb begin
    addrD = addrQ;
    if (stateQ == IDLE) begin
      if (addrLoadFull) begin
        addrD = regAddr;
      end else if (addrLoadByte) begin
        // A lane select past the top byte matches no lane and leaves addrD as is.
        for (int i = 0; i < NBYTES; i++) begin
          if (int'(addrByteSel) == i) begin
            addrD[i*8 +: 8] = intDIn;
          end
        end
      end
    end else if (stateQ == DONE && incQ) begin
      addrD = addrQ + ADDR_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge sysClock or negedge resetReq) begin
    if (!resetReq) begin
      addrQ    <= '0;
      rdDataQ  <= '0;
      wrDataQ  <= '0;
      isWriteQ <= 1'b0;
      incQ     <= 1'b0;
      waitCnt  <= '0;
    end else begin
      addrQ <= addrD;

      if (stateQ == IDLE && (rdReq || wrReq)) begin
        isWriteQ <= ~rdReq;
        incQ     <= incAfter;
        wrDataQ  <= intDIn;
      end

      // Counter is armed in SETUP so it holds WAIT_STATES in the first ACCESS cycle.
      if (stateQ == SETUP) begin
        waitCnt <= 4'(WAIT_STATES);
      end else if (stateQ == ACCESS && waitCnt != 4'd0) begin
        waitCnt <= waitCnt - 4'd1;
      end

      if (stateQ == ACCESS && accessExit && !isWriteQ) begin
        rdDataQ <= extD;
      end
    end
  end

endmodule

// File: tb/tb_r88_memctl.sv
// tb/tb_r88_memctl.sv - self-checking bench for r88_memctl
`timescale 1ns/1ps
module tb_r88_memctl;

  localparam int AW  = 16;
  localparam int WS  = 1;
  localparam int BW  = 24;
  localparam int BWS = 0;

  logic sysClock = 1'b0;
  logic resetReq;
  always #5 sysClock = ~sysClock;

  // DUT A: 16-bit address, one wait state
  logic [AW-1:0] extA, regAddr;
  wire  [7:0]    extD;
  logic          readMem, writeMem, memReady, addrLoadFull, addrLoadByte;
  logic [0:0]    addrByteSel;
  logic [7:0]    intDIn, rdData;
  logic          rdReq, wrReq, incAfter, busy, done;

  r88_memctl #(.ADDR_W(AW), .WAIT_STATES(WS)) dut (
    .sysClock(sysClock), .resetReq(resetReq), .extA(extA), .extD(extD),
    .readMem(readMem), .writeMem(writeMem), .memReady(memReady),
    .regAddr(regAddr), .addrLoadFull(addrLoadFull), .addrLoadByte(addrLoadByte),
    .addrByteSel(addrByteSel), .intDIn(intDIn), .rdReq(rdReq), .wrReq(wrReq),
    .incAfter(incAfter), .rdData(rdData), .busy(busy), .done(done)
  );

  // Memory device for DUT A; probe drives a known value to test bus release
  logic [7:0] devMem [256];
  logic       clearMem, ovEn, probeEn;
  logic [7:0] ovVal, probeVal;
  assign extD = probeEn ? probeVal : (readMem ? (ovEn ? ovVal : devMem[extA[7:0]]) : 8'bz);

  always @(posedge sysClock) begin
    if (clearMem) begin
      for (int i = 0; i < 256; i++) devMem[i] <= 8'(i * 7 + 3);
    end else if (writeMem) begin
      devMem[extA[7:0]] <= extD;
    end
  end

  // DUT B: 24-bit address, no wait states
  logic [BW-1:0] bExtA, bRegAddr;
  wire  [7:0]    bExtD;
  logic          bReadMem, bWriteMem, bReady, bLoadFull, bLoadByte;
  logic [1:0]    bSel;
  logic [7:0]    bDin, bRdData, bRdVal;
  logic          bRdReq, bWrReq, bInc, bBusy, bDone;
  assign bExtD = bReadMem ? bRdVal : 8'bz;

  r88_memctl #(.ADDR_W(BW), .WAIT_STATES(BWS)) dutB (
    .sysClock(sysClock), .resetReq(resetReq), .extA(bExtA), .extD(bExtD),
    .readMem(bReadMem), .writeMem(bWriteMem), .memReady(bReady),
    .regAddr(bRegAddr), .addrLoadFull(bLoadFull), .addrLoadByte(bLoadByte),
    .addrByteSel(bSel), .intDIn(bDin), .rdReq(bRdReq), .wrReq(bWrReq),
    .incAfter(bInc), .rdData(bRdData), .busy(bBusy), .done(bDone)
  );

  int total = 0;
  int bad   = 0;

  // Reference model of DUT A: memory contents, address register, last read
  logic [7:0]    mMem [256];
  logic [AW-1:0] mAddr;
  logic [7:0]    mRd;

  // Observations from the last runOp
  int obsRd, obsWr, obsDoneAt, obsErr, obsWdErr, obsRelErr;

  function automatic int expStrobes(input int waitStates, input int lowCycles);
`ifdef R88_MEMCTL_READY_EN
    return (lowCycles > waitStates) ? lowCycles + 1 : waitStates + 1;
`else
    return waitStates + 1 + 0 * lowCycles;
`endif
  endfunction

  task automatic tick;
    @(posedge sysClock);
    #1;
  endtask

  task automatic loadAddr(input logic [AW-1:0] a);
    regAddr = a; addrLoadFull = 1'b1;
    tick();
    addrLoadFull = 1'b0;
    mAddr = a;
  endtask

  // Issues one request and observes every cycle until one cycle after DONE.
  task automatic runOp(input bit doRd, input bit doWr, input bit inc, input logic [7:0] wd,
                       input int lowCycles, input logic [AW-1:0] expA);
    int seen;
    seen = 0;
    obsRd = 0; obsWr = 0; obsDoneAt = -1; obsErr = 0; obsWdErr = 0; obsRelErr = 0;
    rdReq = doRd; wrReq = doWr; incAfter = inc; intDIn = wd;
    memReady = (lowCycles == 0);
    tick();
    rdReq = 1'b0; wrReq = 1'b0; incAfter = 1'b0; addrLoadFull = 1'b0; addrLoadByte = 1'b0;
    intDIn = 8'($urandom);
    for (int i = 1; i <= 60; i++) begin
      if (readMem || writeMem) begin
        memReady = (seen >= lowCycles);
        seen++;
      end
      if (readMem === 1'b1) obsRd++;
      if (writeMem === 1'b1) obsWr++;
      if (busy !== 1'b1 || extA !== expA) obsErr++;
      if (i == 1 && (readMem || writeMem)) obsErr++;
      if (doWr && !doRd && (i == 1 || writeMem) && extD !== wd) obsWdErr++;
      if (done === 1'b1) begin
        obsDoneAt = i;
        probeVal = ~wd; probeEn = 1'b1; #1;
        if (extD !== probeVal) obsRelErr++;
        probeEn = 1'b0;
        break;
      end
      tick();
    end
    memReady = 1'b1;
    tick();
    if (busy !== 1'b0 || done !== 1'b0) obsErr++;
    probeVal = wd ^ 8'h5A; probeEn = 1'b1; #1;
    if (extD !== probeVal) obsRelErr++;
    probeEn = 1'b0;
  endtask

  task automatic test_reset;
    resetReq = 1'b0; clearMem = 1'b1;
    tick(); tick(); tick();
    total++; if (extA !== 16'h0000) begin bad++; $display("FAIL reset_extA: got %h want 0000", extA); end
    total++; if ({readMem, writeMem, busy, done} !== 4'b0000) begin bad++; $display("FAIL reset_ctrl: got %b want 0000", {readMem, writeMem, busy, done}); end
    total++; if (rdData !== 8'h00) begin bad++; $display("FAIL reset_rdData: got %h want 00", rdData); end
    probeVal = 8'hC3; probeEn = 1'b1; #1;
    total++; if (extD !== 8'hC3) begin bad++; $display("FAIL reset_extD_release: got %h want c3", extD); end
    probeEn = 1'b0;
    resetReq = 1'b1; clearMem = 1'b0;
    tick();
  endtask

  task automatic test_basic_read;
    loadAddr(16'h1234);
    ovEn = 1'b1; ovVal = 8'hA5;
    runOp(1'b1, 1'b0, 1'b0, 8'($urandom), 0, 16'h1234);
    ovEn = 1'b0; mRd = 8'hA5;
    total++; if (obsRd !== WS + 1 || obsWr !== 0) begin bad++; $display("FAIL read_strobes: got rd=%0d wr=%0d want rd=%0d wr=0", obsRd, obsWr, WS + 1); end
    total++; if (obsDoneAt !== WS + 3) begin bad++; $display("FAIL read_latency: got %0d want %0d", obsDoneAt, WS + 3); end
    total++; if (obsErr !== 0) begin bad++; $display("FAIL read_phase: got %0d errors want 0", obsErr); end
    total++; if (rdData !== 8'hA5) begin bad++; $display("FAIL read_data: got %h want a5", rdData); end
    total++; if (extA !== 16'h1234) begin bad++; $display("FAIL read_addr_hold: got %h want 1234", extA); end
  endtask

  task automatic test_basic_write;
    loadAddr(16'h00FF);
    runOp(1'b0, 1'b1, 1'b0, 8'h3C, 0, 16'h00FF);
    mMem[8'hFF] = 8'h3C;
    total++; if (obsWr !== WS + 1 || obsRd !== 0) begin bad++; $display("FAIL write_strobes: got wr=%0d rd=%0d want wr=%0d rd=0", obsWr, obsRd, WS + 1); end
    total++; if (obsWdErr !== 0) begin bad++; $display("FAIL write_data_bus: got %0d bad cycles want 0", obsWdErr); end
    total++; if (obsRelErr !== 0) begin bad++; $display("FAIL write_release: got %0d driven cycles want 0", obsRelErr); end
    total++; if (obsDoneAt !== WS + 3 || obsErr !== 0) begin bad++; $display("FAIL write_timing: got done=%0d err=%0d want %0d/0", obsDoneAt, obsErr, WS + 3); end
    total++; if (rdData !== mRd) begin bad++; $display("FAIL write_rdData_hold: got %h want %h", rdData, mRd); end
  endtask

  task automatic test_wrap;
    loadAddr(16'hFFFF);
    runOp(1'b1, 1'b0, 1'b1, 8'h00, 0, 16'hFFFF);
    mRd = mMem[8'hFF]; mAddr = 16'h0000;
    total++; if (extA !== 16'h0000) begin bad++; $display("FAIL wrap_addr: got %h want 0000", extA); end
    total++; if (rdData !== mRd) begin bad++; $display("FAIL wrap_data: got %h want %h", rdData, mRd); end
  endtask

  task automatic test_collision;
    int wrSeen;
    int doneSeen;
    loadAddr(16'h0042);
    runOp(1'b1, 1'b1, 1'b0, 8'($urandom), 0, 16'h0042);
    mRd = mMem[8'h42];
    total++; if (obsWr !== 0 || obsRd !== WS + 1) begin bad++; $display("FAIL both_req_read_only: got rd=%0d wr=%0d want rd=%0d wr=0", obsRd, obsWr, WS + 1); end
    total++; if (rdData !== mRd) begin bad++; $display("FAIL both_req_data: got %h want %h", rdData, mRd); end
    rdReq = 1'b1;
    tick();
    rdReq = 1'b0;
    wrReq = 1'b1; regAddr = 16'hBEEF; addrLoadFull = 1'b1; addrLoadByte = 1'b1;
    addrByteSel = 1'b0; intDIn = 8'hEE;
    wrSeen = 0; doneSeen = 0;
    for (int i = 0; i < 20 && doneSeen == 0; i++) begin
      tick();
      if (writeMem === 1'b1) wrSeen++;
      if (done === 1'b1) doneSeen = 1;
    end
    wrReq = 1'b0; addrLoadFull = 1'b0; addrLoadByte = 1'b0;
    tick();
    total++; if (extA !== 16'h0042) begin bad++; $display("FAIL busy_load_ignored: got %h want 0042", extA); end
    tick();
    total++; if (busy !== 1'b0 || wrSeen !== 0 || doneSeen !== 1) begin bad++; $display("FAIL busy_req_ignored: got busy=%b wr=%0d done=%0d want 0/0/1", busy, wrSeen, doneSeen); end
  endtask

  task automatic test_ready;
    loadAddr(16'h0077);
    runOp(1'b1, 1'b0, 1'b0, 8'h00, 5, 16'h0077);
    mRd = mMem[8'h77];
    total++; if (obsRd !== expStrobes(WS, 5)) begin bad++; $display("FAIL ready_stretch: got %0d strobe cycles want %0d", obsRd, expStrobes(WS, 5)); end
    total++; if (obsDoneAt !== expStrobes(WS, 5) + 2) begin bad++; $display("FAIL ready_latency: got %0d want %0d", obsDoneAt, expStrobes(WS, 5) + 2); end
    total++; if (rdData !== mRd) begin bad++; $display("FAIL ready_data: got %h want %h", rdData, mRd); end
  endtask

  task automatic test_back_to_back;
    int pos [3];
    int n;
    loadAddr(16'h0010);
    rdReq = 1'b1; incAfter = 1'b1;
    n = 0;
    for (int c = 1; c <= 4 * (WS + 4) + 4 && n < 3; c++) begin
      tick();
      if (done === 1'b1) begin
        pos[n] = c;
        n++;
      end
    end
    rdReq = 1'b0; incAfter = 1'b0;
    tick();
    mAddr = 16'h0013; mRd = mMem[8'h12];
    total++; if (n !== 3) begin bad++; $display("FAIL b2b_count: got %0d dones want 3", n); end
    total++; if (n == 3 && (pos[0] !== WS + 3 || pos[1] - pos[0] !== WS + 4 || pos[2] - pos[1] !== WS + 4)) begin
      bad++; $display("FAIL b2b_spacing: got %0d,%0d,%0d want %0d,+%0d,+%0d", pos[0], pos[1], pos[2], WS + 3, WS + 4, WS + 4);
    end
    total++; if (extA !== mAddr || rdData !== mRd) begin bad++; $display("FAIL b2b_result: got %h/%h want %h/%h", extA, rdData, mAddr, mRd); end
  endtask

  task automatic test_byte_load;
    logic [BW-1:0] exp;
    logic [7:0] v;
    int s;
    int sCnt;
    int dAt;
    logic [1:0] sels [4];
    logic [7:0] vals [4];
    sels[0] = 2'd2; sels[1] = 2'd1; sels[2] = 2'd0; sels[3] = 2'd3;
    vals[0] = 8'h12; vals[1] = 8'h34; vals[2] = 8'h56; vals[3] = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      bSel = sels[k]; bDin = vals[k]; bLoadByte = 1'b1;
      tick();
    end
    bLoadByte = 1'b0;
    total++; if (bExtA !== 24'h123456) begin bad++; $display("FAIL byte_load: got %h want 123456", bExtA); end
    bRegAddr = 24'hABCDEF; bLoadFull = 1'b1; bLoadByte = 1'b1; bSel = 2'd0; bDin = 8'h00;
    tick();
    bLoadFull = 1'b0; bLoadByte = 1'b0;
    total++; if (bExtA !== 24'hABCDEF) begin bad++; $display("FAIL full_priority: got %h want abcdef", bExtA); end
    exp = 24'hABCDEF;
    for (int k = 0; k < 8; k++) begin
      s = $urandom_range(0, 3);
      v = 8'($urandom);
      bSel = 2'(s); bDin = v; bLoadByte = 1'b1;
      tick();
      if (s < 3) exp[s*8 +: 8] = v;
    end
    bLoadByte = 1'b0;
    total++; if (bExtA !== exp) begin bad++; $display("FAIL byte_load_random: got %h want %h", bExtA, exp); end
    bRdVal = 8'($urandom); bRdReq = 1'b1; bInc = 1'b1;
    tick();
    bRdReq = 1'b0; bInc = 1'b0;
    sCnt = 0; dAt = -1;
    for (int i = 1; i <= 20; i++) begin
      if (bReadMem === 1'b1) sCnt++;
      if (bWriteMem === 1'b1) sCnt += 100;
      if (bDone === 1'b1) begin dAt = i; break; end
      tick();
    end
    tick();
    total++; if (sCnt !== BWS + 1 || dAt !== BWS + 3) begin bad++; $display("FAIL b_read_timing: got strobes=%0d done=%0d want %0d/%0d", sCnt, dAt, BWS + 1, BWS + 3); end
    total++; if (bRdData !== bRdVal || bExtA !== exp + 24'd1 || bBusy !== 1'b0) begin
      bad++; $display("FAIL b_read_result: got %h/%h/%b want %h/%h/0", bRdData, bExtA, bBusy, bRdVal, exp + 24'd1);
    end
  endtask

  task automatic test_random;
    bit doRd, inc;
    logic [7:0] wd;
    logic [AW-1:0] a;
    int kind;
    int sel;
    for (int it = 0; it < 24; it++) begin
      kind = $urandom_range(0, 2);
      a = 16'($urandom);
      if (kind == 0) begin
        loadAddr(a);
      end else if (kind == 1) begin
        sel = $urandom_range(0, 1);
        addrByteSel = 1'(sel); intDIn = a[7:0]; addrLoadByte = 1'b1;
        tick();
        addrLoadByte = 1'b0;
        mAddr[sel*8 +: 8] = a[7:0];
      end else begin
        regAddr = a; addrLoadFull = 1'b1;
        mAddr = a;
      end
      doRd = 1'($urandom);
      inc  = 1'($urandom);
      wd   = 8'($urandom);
      runOp(doRd, !doRd, inc, wd, 0, mAddr);
      if (doRd) mRd = mMem[mAddr[7:0]];
      else      mMem[mAddr[7:0]] = wd;
      if (inc) mAddr = mAddr + 16'd1;
      total++; if ((doRd ? obsRd : obsWr) !== WS + 1 || obsDoneAt !== WS + 3) begin
        bad++; $display("FAIL rand_timing[%0d]: got strobes=%0d done=%0d want %0d/%0d", it, doRd ? obsRd : obsWr, obsDoneAt, WS + 1, WS + 3);
      end
      total++; if (obsErr + obsWdErr + obsRelErr !== 0) begin
        bad++; $display("FAIL rand_bus[%0d]: got phase=%0d wdata=%0d release=%0d want 0", it, obsErr, obsWdErr, obsRelErr);
      end
      total++; if (rdData !== mRd || extA !== mAddr) begin
        bad++; $display("FAIL rand_state[%0d]: got %h/%h want %h/%h", it, rdData, extA, mRd, mAddr);
      end
    end
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < 2; k++) begin
      loadAddr(16'h5555);
      rdReq = (k == 0); wrReq = (k != 0); intDIn = 8'h81;
      tick();
      rdReq = 1'b0; wrReq = 1'b0;
      tick();
      total++; if ((k == 0 ? readMem : writeMem) !== 1'b1) begin bad++; $display("FAIL mid_access_strobe[%0d]: got 0 want 1", k); end
      #2 resetReq = 1'b0;
      #1;
      total++; if ({readMem, writeMem, busy, done} !== 4'b0000) begin bad++; $display("FAIL async_reset_ctrl[%0d]: got %b want 0000", k, {readMem, writeMem, busy, done}); end
      total++; if (extA !== 16'h0000) begin bad++; $display("FAIL async_reset_addr[%0d]: got %h want 0000", k, extA); end
      probeVal = 8'h7E; probeEn = 1'b1; #1;
      total++; if (extD !== 8'h7E) begin bad++; $display("FAIL async_reset_release[%0d]: got %h want 7e", k, extD); end
      probeEn = 1'b0;
      resetReq = 1'b1;
      tick();
      total++; if (rdData !== 8'h00 || busy !== 1'b0) begin bad++; $display("FAIL post_reset[%0d]: got %h/%b want 00/0", k, rdData, busy); end
      mAddr = '0; mRd = '0;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    resetReq = 1'b0; clearMem = 1'b1; ovEn = 1'b0; ovVal = '0; probeEn = 1'b0; probeVal = '0;
    memReady = 1'b1; regAddr = '0; addrLoadFull = 1'b0; addrLoadByte = 1'b0; addrByteSel = '0;
    intDIn = '0; rdReq = 1'b0; wrReq = 1'b0; incAfter = 1'b0;
    bRegAddr = '0; bLoadFull = 1'b0; bLoadByte = 1'b0; bSel = '0; bDin = '0;
    bRdReq = 1'b0; bWrReq = 1'b0; bInc = 1'b0; bReady = 1'b1; bRdVal = '0;
    for (int i = 0; i < 256; i++) mMem[i] = 8'(i * 7 + 3);
    mAddr = '0; mRd = '0;

    test_reset();
    test_basic_read();
    test_basic_write();
    test_wrap();
    test_collision();
    test_ready();
    test_back_to_back();
    test_byte_load();
    test_random();
    test_reset_mid();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
